// File: rtl/somador_pkg.sv
// Shared types and constants for the sequential multi-byte adder.
package somador_pkg;
  localparam int BYTE_W = 8;
  typedef enum logic [1:0] {IDLE, ADD, DONE} somador_state_t;
endpackage

// File: rtl/oitobitsadder.sv
// 8-bit ripple-carry adder: one full-adder cell per bit, carry chained LSB to MSB.
module oitobitsadder
  import somador_pkg::*;
(
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  input  logic              cin,
  output logic [BYTE_W-1:0] s,
  output logic              cout
);
  logic [BYTE_W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < BYTE_W; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[BYTE_W];
endmodule

// File: rtl/somador_multibyte.sv
// Sequential multi-byte adder: one byte per clock, LSB first, through a single
// 8-bit ripple adder with the inter-byte carry held in a register.
//
//   state | meaning
//   IDLE  | in_ready=1, waiting for operands
//   ADD   | adding byte[idx] of captured operands, carry kept in register
//   DONE  | out_valid=1, result held until out_ready
module somador_multibyte
  import somador_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [8*NBYTES-1:0]  a,
  input  logic [8*NBYTES-1:0]  b,
  input  logic                 cin,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [8*NBYTES-1:0]  sum,
  output logic                 cout,
  output logic                 ovf
);
  localparam int W    = BYTE_W * NBYTES;
  localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(NBYTES - 1);

  somador_state_t    state;
  logic [W-1:0]      opa;
  logic [W-1:0]      opb;
  logic              carry;
  logic [IDXW-1:0]   idx;

  logic [BYTE_W-1:0] add_a;
  logic [BYTE_W-1:0] add_b;
  logic [BYTE_W-1:0] add_s;
  logic              add_co;

  assign add_a = opa[idx*BYTE_W +: BYTE_W];
  assign add_b = opb[idx*BYTE_W +: BYTE_W];

  oitobitsadder u_add8 (
    .a    (add_a),
    .b    (add_b),
    .cin  (carry),
    .s    (add_s),
    .cout (add_co)
  );

  // Handshake outputs are registered alongside the state so neither depends
  // combinationally on in_valid or out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      opa       <= '0;
      opb       <= '0;
      carry     <= 1'b0;
      idx       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            opa      <= a;
            opb      <= b;
            carry    <= cin;
            idx      <= '0;
            sum      <= '0;
            in_ready <= 1'b0;
            state    <= ADD;
          end
        end
        ADD: begin
          sum[idx*BYTE_W +: BYTE_W] <= add_s;
          carry                     <= add_co;
          if (idx == LAST) begin
            cout      <= add_co;
            ovf       <= (opa[W-1] == opb[W-1]) && (add_s[BYTE_W-1] != opa[W-1]);
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_somador_multibyte.sv
// Self-checking bench for somador_multibyte with NBYTES=4 and NBYTES=1 instances.
module tb_somador_multibyte;
  logic clk;
  logic rst_n;

  logic        iv4, ir4, ov4, or4, cin4, co4, of4;
  logic [31:0] a4, b4, s4;
  logic        iv1, ir1, ov1, or1, cin1, co1, of1;
  logic [7:0]  a1, b1, s1;

  int total = 0;
  int bad   = 0;

  somador_multibyte #(.NBYTES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4), .cin(cin4),
    .out_valid(ov4), .out_ready(or4), .sum(s4), .cout(co4), .ovf(of4)
  );

  somador_multibyte #(.NBYTES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1), .cin(cin1),
    .out_valid(ov1), .out_ready(or1), .sum(s1), .cout(co1), .ovf(of1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: plain integer arithmetic on w-bit operands.
  function automatic void ref_add(input int w, input longint unsigned a, input longint unsigned b,
                                  input bit c, output longint unsigned s, output bit co,
                                  output bit ov);
    longint unsigned full;
    longint half, sa, sb, r;
    full = a + b + longint'(c);
    s    = full & ((64'd1 << w) - 64'd1);
    co   = 1'((full >> w) & 64'd1);
    half = longint'(64'd1 << (w - 1));
    sa   = (longint'(a) >= half) ? longint'(a) - 2 * half : longint'(a);
    sb   = (longint'(b) >= half) ? longint'(b) - 2 * half : longint'(b);
    r    = sa + sb + longint'(c);
    ov   = (r > half - 1) || (r < -half);
  endfunction

  task automatic drive_in(input int sel, input bit v, input logic [31:0] a, input logic [31:0] b,
                          input bit c);
    if (sel == 4) begin
      iv4 = v; a4 = a; b4 = b; cin4 = c;
    end else begin
      iv1 = v; a1 = a[7:0]; b1 = b[7:0]; cin1 = c;
    end
  endtask

  task automatic set_ordy(input int sel, input bit r);
    if (sel == 4) or4 = r;
    else or1 = r;
  endtask

  function automatic bit get_ir(input int sel);
    return (sel == 4) ? ir4 : ir1;
  endfunction

  function automatic bit get_ov(input int sel);
    return (sel == 4) ? ov4 : ov1;
  endfunction

  function automatic logic [31:0] get_sum(input int sel);
    return (sel == 4) ? s4 : {24'b0, s1};
  endfunction

  function automatic bit get_co(input int sel);
    return (sel == 4) ? co4 : co1;
  endfunction

  function automatic bit get_of(input int sel);
    return (sel == 4) ? of4 : of1;
  endfunction

  // One full transaction; inputs are scrambled during ADD, out_ready optionally random.
  task automatic run_op(input int sel, input logic [31:0] a, input logic [31:0] b, input bit c,
                        input bit rand_rdy, output logic [31:0] s, output bit co, output bit ov,
                        output int lat);
    int n;
    bit r;
    s = '0; co = 0; ov = 0; lat = -1;
    @(negedge clk);
    drive_in(sel, 1'b1, a, b, c);
    n = 0;
    while (!get_ir(sel) && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    @(negedge clk);
    drive_in(sel, 1'b0, $urandom, $urandom, 1'($urandom));
    n = 0;
    while (!get_ov(sel) && n < 50) begin
      @(posedge clk);
      @(negedge clk);
      drive_in(sel, 1'b0, $urandom, $urandom, 1'($urandom));
      n++;
    end
    if (!get_ov(sel)) begin
      total++; bad++;
      $display("FAIL op_timeout: nbytes=%0d out_valid=%0b required=1", sel, get_ov(sel));
      return;
    end
    lat = n;
    s = get_sum(sel); co = get_co(sel); ov = get_of(sel);
    n = 0;
    do begin
      r = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      if (n > 40) r = 1'b1;
      set_ordy(sel, r);
      @(posedge clk);
      @(negedge clk);
      n++;
    end while (!r);
    set_ordy(sel, 1'b0);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    drive_in(4, 0, 0, 0, 0); drive_in(1, 0, 0, 0, 0);
    or4 = 0; or1 = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if ({ir4, ov4, s4, co4, of4} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset4: got ir=%0b ov=%0b sum=%h co=%0b ovf=%0b required 1 0 0 0 0",
               ir4, ov4, s4, co4, of4);
    end
    total++;
    if ({ir1, ov1, s1, co1, of1} !== {1'b1, 1'b0, 8'h0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset1: got ir=%0b ov=%0b sum=%h co=%0b ovf=%0b required 1 0 0 0 0",
               ir1, ov1, s1, co1, of1);
    end
  endtask

  task automatic test_directed(input string name, input logic [31:0] a, input logic [31:0] b,
                               input bit c, input logic [31:0] es, input bit eco, input bit eov);
    logic [31:0] s;
    bit co, ov;
    int lat;
    run_op(4, a, b, c, 1'b0, s, co, ov, lat);
    total++;
    if ({s, co, ov} !== {es, eco, eov}) begin
      bad++;
      $display("FAIL %s: got sum=%h co=%0b ovf=%0b required sum=%h co=%0b ovf=%0b",
               name, s, co, ov, es, eco, eov);
    end
    total++;
    if (lat != 4) begin
      bad++;
      $display("FAIL %s_latency: got %0d cycles required 4", name, lat);
    end
  endtask

  task automatic test_backpressure;
    longint unsigned es;
    bit eco, eov;
    logic [31:0] s;
    int n;
    ref_add(32, 64'h1234_5678, 64'h9ABC_DEF0, 1'b1, es, eco, eov);
    @(negedge clk);
    drive_in(4, 1, 32'h1234_5678, 32'h9ABC_DEF0, 1);
    @(posedge clk);
    @(negedge clk);
    drive_in(4, 0, 0, 0, 0);
    n = 0;
    while (!ov4 && n < 20) begin @(negedge clk); n++; end
    drive_in(4, 1, 32'h0000_0003, 32'h0000_0004, 0);
    or4 = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if ({ov4, ir4, s4, co4, of4} !== {1'b1, 1'b0, es[31:0], eco, eov}) begin
        bad++;
        $display("FAIL stall_hold[%0d]: got ov=%0b ir=%0b sum=%h co=%0b ovf=%0b required 1 0 %h %0b %0b",
                 i, ov4, ir4, s4, co4, of4, es[31:0], eco, eov);
      end
    end
    or4 = 1;
    @(posedge clk);
    @(negedge clk);
    or4 = 0;
    total++;
    if ({ov4, ir4} !== 2'b01) begin
      bad++;
      $display("FAIL stall_release: got ov=%0b ir=%0b required 0 1", ov4, ir4);
    end
    @(posedge clk);
    @(negedge clk);
    drive_in(4, 0, 0, 0, 0);
    total++;
    if (ir4 !== 1'b0) begin
      bad++;
      $display("FAIL stall_next_accept: got ir=%0b required 0", ir4);
    end
    n = 0;
    while (!ov4 && n < 20) begin @(negedge clk); n++; end
    s = s4;
    or4 = 1;
    @(posedge clk);
    @(negedge clk);
    or4 = 0;
    total++;
    if (s !== 32'd7) begin
      bad++;
      $display("FAIL stall_next_sum: got %h required 00000007", s);
    end
  endtask

  task automatic test_reset_mid_op;
    logic [31:0] s;
    bit co, ov;
    int lat;
    @(negedge clk);
    drive_in(4, 1, 32'hDEAD_BEEF, 32'h0101_0101, 1);
    @(posedge clk);
    @(negedge clk);
    drive_in(4, 0, 0, 0, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    total++;
    if ({ov4, ir4, s4} !== {1'b0, 1'b1, 32'h0}) begin
      bad++;
      $display("FAIL midreset_async: got ov=%0b ir=%0b sum=%h required 0 1 0", ov4, ir4, s4);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if ({ov4, ir4, s4} !== {1'b0, 1'b1, 32'h0}) begin
      bad++;
      $display("FAIL midreset_release: got ov=%0b ir=%0b sum=%h required 0 1 0", ov4, ir4, s4);
    end
    run_op(4, 32'd5, 32'd7, 1'b0, 1'b0, s, co, ov, lat);
    total++;
    if ({s, co, ov} !== {32'd12, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL midreset_next: got sum=%h co=%0b ovf=%0b required 0000000c 0 0", s, co, ov);
    end
  endtask

  task automatic test_random(input int sel, input int nops);
    logic [31:0] a, b, s;
    bit c, co, ov, eco, eov;
    longint unsigned es;
    int lat;
    for (int i = 0; i < nops; i++) begin
      a = $urandom;
      b = $urandom;
      if (i % 8 == 0) a = (sel == 4) ? 32'hFFFF_FFFF : 32'h0000_00FF;
      if (sel == 1) begin a = a & 32'hFF; b = b & 32'hFF; end
      c = 1'($urandom);
      ref_add(sel * 8, longint'(a), longint'(b), c, es, eco, eov);
      run_op(sel, a, b, c, 1'b1, s, co, ov, lat);
      total++;
      if ({s, co, ov} !== {es[31:0], eco, eov} || lat != sel) begin
        bad++;
        $display("FAIL random%0d[%0d]: a=%h b=%h cin=%0b got sum=%h co=%0b ovf=%0b lat=%0d required sum=%h co=%0b ovf=%0b lat=%0d",
                 sel, i, a, b, c, s, co, ov, lat, es[31:0], eco, eov, sel);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed("carry_ripple", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    test_directed("signed_ovf",   32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    test_directed("carry_in",     32'h0000_00FF, 32'h0000_0000, 1'b1, 32'h0000_0100, 1'b0, 1'b0);
    test_directed("neg_ovf",      32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1);
    test_backpressure();
    test_reset_mid_op();
    test_random(4, 1000);
    test_random(1, 1000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
